// File: rtl/pwm_fade_seq_if.sv
// pwm_fade_seq_if: CPU config/strobes, PWM wrap and the period/duty outputs of the fade sequencer
interface pwm_fade_seq_if #(
  parameter int W = 28,
  parameter int HW = 16
);
  logic [W-1:0] cfg_period, cfg_target, cfg_step, period_out, decode_out;
  logic [HW-1:0] cfg_hold;
  logic cfg_load, pwm_wrap, busy, done;
  modport master (
    output cfg_period, cfg_target, cfg_step, cfg_hold, cfg_load, pwm_wrap,
    input  period_out, decode_out, busy, done
  );
  modport slave (
    input  cfg_period, cfg_target, cfg_step, cfg_hold, cfg_load, pwm_wrap,
    output period_out, decode_out, busy, done
  );
endinterface

// File: rtl/pwm_fade_seq.sv
// pwm_fade_seq: ramps the PWM duty toward a target in fixed steps, updating only on the PWM wrap strobe
module pwm_fade_seq #(
  parameter int W = 28,
  parameter int HW = 16,
  parameter int unsigned PERIOD_RST = 1000
) (
  input logic CLK,
  input logic RST_N,
  pwm_fade_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, RAMP} state_t;
  localparam logic [W-1:0] P_RST = W'(PERIOD_RST);
  state_t state, state_d;
  logic [W-1:0] sh_period, sh_target, sh_step, period_q, decode_q;
  logic [W-1:0] sh_period_d, sh_target_d, sh_step_d, period_d, decode_d;
  logic [HW-1:0] sh_hold, sh_hold_d, hold_cnt, hold_cnt_d, hold_inc;
  logic [W-1:0] cap_period, clamped, diff;
  logic done_q, done_d, step_now, last, up;
  always_comb begin
    cap_period = bus.cfg_period == '0 ? W'(1) : bus.cfg_period;
    clamped = decode_q > sh_period ? sh_period : decode_q;
    up = sh_target > decode_q;
    diff = up ? sh_target - decode_q : decode_q - sh_target;
    hold_inc = hold_cnt + 1'b1;
    step_now = hold_inc == sh_hold;
    last = sh_step == '0 || diff <= sh_step;
    state_d = state;
    sh_period_d = sh_period;
    sh_target_d = sh_target;
    sh_step_d = sh_step;
    sh_hold_d = sh_hold;
    hold_cnt_d = hold_cnt;
    period_d = period_q;
    decode_d = decode_q;
    done_d = 1'b0;
    if (bus.cfg_load) begin
      sh_period_d = cap_period;
      sh_target_d = bus.cfg_target > cap_period ? cap_period : bus.cfg_target;
      sh_step_d = bus.cfg_step;
      sh_hold_d = bus.cfg_hold == '0 ? HW'(1) : bus.cfg_hold;
      hold_cnt_d = '0;
      state_d = ARMED;
    end else if (bus.pwm_wrap && state == ARMED) begin
      period_d = sh_period;
      decode_d = clamped;
      hold_cnt_d = '0;
      done_d = clamped == sh_target;
      state_d = clamped == sh_target ? IDLE : RAMP;
    end else if (bus.pwm_wrap && state == RAMP) begin
      hold_cnt_d = step_now ? '0 : hold_inc;
      if (step_now) begin
        decode_d = last ? sh_target : up ? decode_q + sh_step : decode_q - sh_step;
        done_d = last;
        state_d = last ? IDLE : RAMP;
      end
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      sh_period <= P_RST;
      sh_target <= '0;
      sh_step <= '0;
      sh_hold <= HW'(1);
      hold_cnt <= '0;
      period_q <= P_RST;
      decode_q <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_d;
      sh_period <= sh_period_d;
      sh_target <= sh_target_d;
      sh_step <= sh_step_d;
      sh_hold <= sh_hold_d;
      hold_cnt <= hold_cnt_d;
      period_q <= period_d;
      decode_q <= decode_d;
      done_q <= done_d;
    end
  end
  assign bus.period_out = period_q;
  assign bus.decode_out = decode_q;
  assign bus.done = done_q;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_pwm_fade_seq.sv
// tb_pwm_fade_seq: randomized wrap timing checked against a per-sequence arithmetic model of the fade
module tb_pwm_fade_seq;
  localparam int W = 28;
  localparam int HW = 16;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int total = 0;
  int bad = 0;
  logic [W-1:0] m_period = W'(1000);
  logic [W-1:0] m_decode = '0;
  pwm_fade_seq_if #(.W(W), .HW(HW)) bus ();
  pwm_fade_seq #(.W(W), .HW(HW), .PERIOD_RST(1000)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_seq(input logic [W-1:0] per, tgt, stp, input logic [HW-1:0] hld,
                         input int max_wraps, input bit collide, input string name);
    logic [W-1:0] p, t, diff;
    int h, w;
    bit fin;
    p = (per == '0) ? W'(1) : per;
    t = (tgt > p) ? p : tgt;
    h = (hld == '0) ? 1 : int'(hld);
    bus.cfg_period = per;
    bus.cfg_target = tgt;
    bus.cfg_step = stp;
    bus.cfg_hold = hld;
    bus.cfg_load = 1'b1;
    bus.pwm_wrap = collide;
    tick;
    bus.cfg_load = 1'b0;
    bus.pwm_wrap = 1'b0;
    total++;
    if (bus.period_out !== m_period || bus.decode_out !== m_decode || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL %s load: period=%0d decode=%0d done=%b busy=%b, need period=%0d decode=%0d done=0 busy=1",
               name, bus.period_out, bus.decode_out, bus.done, bus.busy, m_period, m_decode);
    end
    fin = 1'b0;
    w = 0;
    while (!fin && w < max_wraps) begin
      repeat ($urandom_range(0, 2)) begin
        tick;
        total++;
        if (bus.period_out !== m_period || bus.decode_out !== m_decode || bus.done !== 1'b0) begin
          bad++;
          $display("FAIL %s gap before wrap %0d: period=%0d decode=%0d done=%b, need %0d %0d 0",
                   name, w + 1, bus.period_out, bus.decode_out, bus.done, m_period, m_decode);
        end
      end
      bus.pwm_wrap = 1'b1;
      tick;
      bus.pwm_wrap = 1'b0;
      w++;
      if (w == 1) begin
        m_period = p;
        m_decode = (m_decode > p) ? p : m_decode;
        fin = (m_decode == t);
      end else if ((w - 1) % h == 0) begin
        diff = (m_decode > t) ? m_decode - t : t - m_decode;
        fin = (stp == '0) || (diff <= stp);
        m_decode = fin ? t : (m_decode < t) ? m_decode + stp : m_decode - stp;
      end
      total++;
      if (bus.period_out !== m_period || bus.decode_out !== m_decode || bus.done !== fin || bus.busy !== !fin) begin
        bad++;
        $display("FAIL %s wrap %0d: period=%0d decode=%0d done=%b busy=%b, need period=%0d decode=%0d done=%b busy=%b",
                 name, w, bus.period_out, bus.decode_out, bus.done, bus.busy, m_period, m_decode, fin, !fin);
      end
    end
    if (fin) begin
      tick;
      bus.pwm_wrap = 1'b1;
      tick;
      bus.pwm_wrap = 1'b0;
      total++;
      if (bus.period_out !== m_period || bus.decode_out !== m_decode || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL %s idle wrap: period=%0d decode=%0d done=%b busy=%b, need %0d %0d 0 0",
                 name, bus.period_out, bus.decode_out, bus.done, bus.busy, m_period, m_decode);
      end
    end
  endtask

  task automatic test_reset;
    bus.cfg_period = '0;
    bus.cfg_target = '0;
    bus.cfg_step = '0;
    bus.cfg_hold = '0;
    bus.cfg_load = 1'b0;
    bus.pwm_wrap = 1'b0;
    repeat (3) tick;
    RST_N = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.pwm_wrap = ~bus.pwm_wrap;
      tick;
      total++;
      if (bus.period_out !== W'(1000) || bus.decode_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: period=%0d decode=%0d busy=%b done=%b, need 1000 0 0 0",
                 i, bus.period_out, bus.decode_out, bus.busy, bus.done);
      end
    end
    bus.pwm_wrap = 1'b0;
  endtask

  task automatic test_ramp_up;
    run_seq(W'(200), W'(100), W'(30), HW'(2), 100000, 1'b0, "ramp_up");
    total++;
    if (bus.decode_out !== W'(100) || bus.period_out !== W'(200)) begin
      bad++;
      $display("FAIL ramp_up final: period=%0d decode=%0d, need 200 100", bus.period_out, bus.decode_out);
    end
  endtask

  task automatic test_ramp_down;
    run_seq(W'(200), W'(10), W'(40), HW'(1), 100000, 1'b0, "ramp_down");
    total++;
    if (bus.decode_out !== W'(10)) begin
      bad++;
      $display("FAIL ramp_down final: decode=%0d, need 10", bus.decode_out);
    end
  endtask

  task automatic test_clamp_jump;
    run_seq(W'(200), W'(500), W'(0), HW'(1), 100000, 1'b0, "clamp_jump");
    total++;
    if (bus.decode_out !== W'(200) || bus.period_out !== W'(200)) begin
      bad++;
      $display("FAIL clamp_jump final: period=%0d decode=%0d, need 200 200", bus.period_out, bus.decode_out);
    end
  endtask

  task automatic test_load_collision;
    run_seq(W'(200), W'(150), W'(30), HW'(1), 2, 1'b0, "collide_pre");
    run_seq(W'(200), W'(0), W'(0), HW'(1), 100000, 1'b1, "collide");
    total++;
    if (bus.decode_out !== '0) begin
      bad++;
      $display("FAIL collide final: decode=%0d, need 0", bus.decode_out);
    end
  endtask

  task automatic test_reset_mid;
    run_seq(W'(200), W'(100), W'(30), HW'(1), 3, 1'b0, "reset_mid_pre");
    total++;
    if (bus.decode_out !== W'(60) || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid setup: decode=%0d busy=%b, need 60 1", bus.decode_out, bus.busy);
    end
    #2 RST_N = 1'b0;
    #1;
    total++;
    if (bus.period_out !== W'(1000) || bus.decode_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid async: period=%0d decode=%0d busy=%b done=%b, need 1000 0 0 0",
               bus.period_out, bus.decode_out, bus.busy, bus.done);
    end
    m_period = W'(1000);
    m_decode = '0;
    repeat (2) tick;
    RST_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.pwm_wrap = (i % 2 == 0);
      tick;
      total++;
      if (bus.period_out !== W'(1000) || bus.decode_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid after cycle %0d: period=%0d decode=%0d busy=%b done=%b, need 1000 0 0 0",
                 i, bus.period_out, bus.decode_out, bus.busy, bus.done);
      end
    end
    bus.pwm_wrap = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) begin
      run_seq(W'($urandom_range(0, 300)), W'($urandom_range(0, 400)),
              ($urandom_range(0, 4) == 0) ? W'(0) : W'($urandom_range(1, 60)),
              HW'($urandom_range(0, 3)), 100000, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset;
    test_ramp_up;
    test_ramp_down;
    test_clamp_jump;
    test_load_collision;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
